c3_prio_queue: RTL and testbench
================================

C3_PRIO_QUEUE -- requirements
Module: c3_prio_queue

Interface
REQ-001 Parameter DATA_W, default 32, key/data width.
REQ-002 Parameter DEPTH, default 32, max entries; any integer >= 2, not required to be a power of two.
REQ-003 Parameter MIN_MODE, default 0: 0 = max-priority (root largest), 1 = min-priority (root smallest).
REQ-004 Parameter SIGNED_CMP, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-005 Derived CNT_W = $clog2(DEPTH+1), so count can represent DEPTH.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 in_v  in  1  command valid, sampled only when busy=0.
REQ-009 rd  in  5  rd[2:0] opcode, full rd echoed on out_rd.
REQ-010 in_data  in  DATA_W  command operand.
REQ-011 out_v  out  1  one-cycle response strobe.
REQ-012 out_rd  out  5  rd of the responded command.
REQ-013 out_data  out  DATA_W  response value.
REQ-014 out_err  out  1  valid with out_v; command failed.
REQ-015 busy  out  1  high while restructuring; commands ignored.
REQ-016 count  out  CNT_W  current entry count.
REQ-017 full / empty  out  1 each  count==DEPTH / count==0.

Function
REQ-018 Accept = in_v & ~busy; each accepted command yields exactly one out_v pulse in the next cycle; no response for ignored commands.
REQ-019 Opcodes: 0 PUSH, 1 POP, 2 PEEK, 3 COUNT, 4 CLEAR, 5 REPLACE (pop root and insert in_data), 6-7 illegal.
REQ-020 PUSH, not full: write in_data at index count, count+1, out_data = new count zero-extended, enter SIFT_UP; full: no change, out_err=1, out_data=0.
REQ-021 POP, not empty: out_data = root (value before the command), move last entry to root, count-1, enter SIFT_DOWN; empty: out_err=1, out_data=0.
REQ-022 PEEK: out_data = root, no state change; empty: out_err=1, out_data=0.
REQ-023 COUNT: out_data = count zero-extended, never errors.
REQ-024 CLEAR: count=0 in one cycle, array contents left stale, out_data=0.
REQ-025 REPLACE, not empty: out_data = old root, root = in_data, count unchanged, enter SIFT_DOWN; empty: out_err=1, no change.
REQ-026 Illegal opcode: out_err=1, out_data=0, no state change.
REQ-027 FSM states IDLE, SIFT_UP, SIFT_DOWN; busy = (state != IDLE), registered, so busy is high the cycle after an accepted PUSH/POP/REPLACE.
REQ-028 SIFT_UP: one parent compare/swap per cycle; return to IDLE when idx==0 or the entry does not beat its parent.
REQ-029 SIFT_DOWN: one level per cycle; compare only children with index < count; pick the better child (left on tie); swap only if the child strictly beats the parent, else return to IDLE.
REQ-030 Equal keys never swap; max busy length = floor(log2 DEPTH) cycles.
REQ-031 POP leaving count 0 or 1 skips SIFT_DOWN (stays IDLE).
REQ-032 Priority "beats": greater (MIN_MODE=0) or less (MIN_MODE=1), signedness per SIGNED_CMP.

Reset
REQ-033 Async reset: state=IDLE, count=0, out_v=0, out_rd=0, out_data=0, out_err=0, busy=0, empty=1, full=0; array storage need not be reset.
REQ-034 Reset asserted mid-sift aborts the sift immediately; after release the queue is empty and idle.

Structure
REQ-035 Package c3_pq_pkg holds opcode constants, FSM state encoding and the CNT_W function.
REQ-036 Sub-module c3_pq_cmp (combinational "a beats b", parametrised by DATA_W, MIN_MODE, SIGNED_CMP) instantiated for parent and child compares.
REQ-037 Storage is a register array (no RAM macro) of DEPTH x DATA_W.

Verification
REQ-038 Max mode: PUSH 5,9,3,7 (waiting for busy=0 between) then POP x4 -> out_data 9,7,5,3, out_err=0, count ends 0.
REQ-039 MIN_MODE=1, SIGNED_CMP=1: PUSH -2,4,-8 then POP -> out_data -8 (0xFFFFFFF8).
REQ-040 DEPTH=5: five PUSHes then a sixth -> sixth out_err=1, full=1, count=5; POP on empty -> out_err=1, out_data=0.
REQ-041 Assert in_v on the cycle busy=1 after a PUSH -> no out_v for that command, heap unchanged.
REQ-042 Heap {10,8,6}: REPLACE 1 -> out_data 10, then PEEK -> 8, COUNT -> 3.
REQ-043 Assert reset during SIFT_DOWN -> next cycle busy=0, count=0, empty=1; subsequent POP -> out_err=1.

Source files
------------

// File: rtl/c3_pq_pkg.sv
// Shared definitions for the c3 priority queue: opcodes, FSM states, width helper.
package c3_pq_pkg;

  localparam logic [2:0] OP_PUSH    = 3'd0;
  localparam logic [2:0] OP_POP     = 3'd1;
  localparam logic [2:0] OP_PEEK    = 3'd2;
  localparam logic [2:0] OP_COUNT   = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;
  localparam logic [2:0] OP_REPLACE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } state_t;

  // Count width able to represent the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/c3_pq_cmp.sv
// Combinational priority compare: o_beats = 1 when i_a strictly outranks i_b.
module c3_pq_cmp #(
  parameter int DATA_W     = 32,
  parameter int MIN_MODE   = 0,
  parameter int SIGNED_CMP = 0
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_beats
);

  logic w_gt;
  logic w_lt;

  generate
    if (SIGNED_CMP != 0) begin : g_signed
      assign w_gt = $signed(i_a) > $signed(i_b);
      assign w_lt = $signed(i_a) < $signed(i_b);
    end else begin : g_unsigned
      assign w_gt = i_a > i_b;
      assign w_lt = i_a < i_b;
    end
  endgenerate

  // Strict compare, so equal keys never count as beating each other.
  assign o_beats = (MIN_MODE != 0) ? w_lt : w_gt;

endmodule

// File: rtl/c3_prio_queue.sv
// Binary-heap priority queue in a register array; one sift level per cycle.
module c3_prio_queue
  import c3_pq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 32,
  parameter int MIN_MODE   = 0,
  parameter int SIGNED_CMP = 0,
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_v,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_v,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [AW-1:0]     r_idx;
  logic [DATA_W-1:0] r_heap [DEPTH];
  logic              r_out_v;
  logic [4:0]        r_out_rd;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_err;

  logic              w_acc, w_full, w_empty;
  logic [2:0]        w_op;
  logic [CNT_W-1:0]  w_cnt_inc, w_cnt_dec;
  logic [AW-1:0]     w_last_a;
  logic [DATA_W-1:0] w_root, w_last, w_cur;

  assign w_acc     = in_v & (r_state == ST_IDLE);
  assign w_op      = rd[2:0];
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_cnt_inc = r_count + CNT_W'(1);
  assign w_cnt_dec = r_count - CNT_W'(1);
  assign w_last_a  = w_empty ? '0 : w_cnt_dec[AW-1:0];
  assign w_root    = r_heap[0];
  assign w_last    = r_heap[w_last_a];
  assign w_cur     = r_heap[r_idx];

  // Sift-up: current entry against its parent.
  logic [AW-1:0]     w_par;
  logic [DATA_W-1:0] w_par_v;
  logic              w_up_beats, w_up_swap;

  assign w_par   = (r_idx - AW'(1)) >> 1;
  assign w_par_v = r_heap[w_par];

  c3_pq_cmp #(.DATA_W(DATA_W), .MIN_MODE(MIN_MODE), .SIGNED_CMP(SIGNED_CMP)) u_cmp_up (
    .i_a(w_cur), .i_b(w_par_v), .o_beats(w_up_beats)
  );

  assign w_up_swap = (r_state == ST_SIFT_UP) && (r_idx != '0) && w_up_beats;

  // Sift-down: child indices are one bit wider so 2*idx+2 never wraps.
  logic [CNT_W:0]    w_idx_x, w_lch, w_rch, w_cnt_x, w_best, w_best_lch;
  logic              w_has_l, w_has_r, w_r_beats_l, w_pick_r, w_dn_beats;
  logic              w_dn_swap, w_best_leaf;
  logic [AW-1:0]     w_l_a, w_r_a, w_best_a;
  logic [DATA_W-1:0] w_l_v, w_r_v, w_best_v;

  assign w_idx_x  = (CNT_W+1)'(r_idx);
  assign w_lch    = (w_idx_x << 1) + (CNT_W+1)'(1);
  assign w_rch    = w_lch + (CNT_W+1)'(1);
  assign w_cnt_x  = {1'b0, r_count};
  assign w_has_l  = (w_lch < w_cnt_x);
  assign w_has_r  = (w_rch < w_cnt_x);
  assign w_l_a    = w_has_l ? w_lch[AW-1:0] : '0;
  assign w_r_a    = w_has_r ? w_rch[AW-1:0] : '0;
  assign w_l_v    = r_heap[w_l_a];
  assign w_r_v    = r_heap[w_r_a];

  c3_pq_cmp #(.DATA_W(DATA_W), .MIN_MODE(MIN_MODE), .SIGNED_CMP(SIGNED_CMP)) u_cmp_ch (
    .i_a(w_r_v), .i_b(w_l_v), .o_beats(w_r_beats_l)
  );

  // Left child wins ties; right only when it strictly beats left.
  assign w_pick_r = w_has_r & w_r_beats_l;
  assign w_best   = w_pick_r ? w_rch : w_lch;
  assign w_best_a = w_pick_r ? w_r_a : w_l_a;
  assign w_best_v = w_pick_r ? w_r_v : w_l_v;

  c3_pq_cmp #(.DATA_W(DATA_W), .MIN_MODE(MIN_MODE), .SIGNED_CMP(SIGNED_CMP)) u_cmp_dn (
    .i_a(w_best_v), .i_b(w_cur), .o_beats(w_dn_beats)
  );

  assign w_dn_swap   = (r_state == ST_SIFT_DOWN) && w_has_l && w_dn_beats;
  // Stop right after a swap into a leaf so busy never exceeds floor(log2 DEPTH).
  assign w_best_lch  = (w_best << 1) + (CNT_W+1)'(1);
  assign w_best_leaf = !(w_best_lch < w_cnt_x);

  // Two array write ports: commands use port A only, swaps use both.
  logic              w_wa_en, w_wb_en;
  logic [AW-1:0]     w_wa_addr, w_wb_addr;
  logic [DATA_W-1:0] w_wa_data, w_wb_data;

  // Decode which array entries change this cycle.
  always_comb begin
    w_wa_en   = 1'b0;
    w_wa_addr = '0;
    w_wa_data = '0;
    w_wb_en   = 1'b0;
    w_wb_addr = '0;
    w_wb_data = '0;
    if (w_acc) begin
      case (w_op)
        OP_PUSH: if (!w_full) begin
          w_wa_en = 1'b1; w_wa_addr = r_count[AW-1:0]; w_wa_data = in_data;
        end
        OP_POP: if (!w_empty) begin
          w_wa_en = 1'b1; w_wa_addr = '0; w_wa_data = w_last;
        end
        OP_REPLACE: if (!w_empty) begin
          w_wa_en = 1'b1; w_wa_addr = '0; w_wa_data = in_data;
        end
        default: ;
      endcase
    end else if (w_up_swap) begin
      w_wa_en = 1'b1; w_wa_addr = r_idx; w_wa_data = w_par_v;
      w_wb_en = 1'b1; w_wb_addr = w_par; w_wb_data = w_cur;
    end else if (w_dn_swap) begin
      w_wa_en = 1'b1; w_wa_addr = r_idx;    w_wa_data = w_best_v;
      w_wb_en = 1'b1; w_wb_addr = w_best_a; w_wb_data = w_cur;
    end
  end

  // Heap storage; contents are don't-care after reset or CLEAR.
  always_ff @(posedge clk) begin
    if (w_wa_en) r_heap[w_wa_addr] <= w_wa_data;
    if (w_wb_en) r_heap[w_wb_addr] <= w_wb_data;
  end

  // Command FSM with registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_idx      <= '0;
      r_out_v    <= 1'b0;
      r_out_rd   <= '0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else begin
      r_out_v <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_acc) begin
          r_out_v    <= 1'b1;
          r_out_rd   <= rd;
          r_out_err  <= 1'b0;
          r_out_data <= '0;
          case (w_op)
            OP_PUSH: if (w_full) r_out_err <= 1'b1;
              else begin
                r_count    <= w_cnt_inc;
                r_out_data <= DATA_W'(w_cnt_inc);
                r_idx      <= r_count[AW-1:0];
                r_state    <= ST_SIFT_UP;
              end
            OP_POP: if (w_empty) r_out_err <= 1'b1;
              else begin
                r_out_data <= w_root;
                r_count    <= w_cnt_dec;
                r_idx      <= '0;
                // A heap of 0 or 1 entries is already ordered.
                if (r_count > CNT_W'(2)) r_state <= ST_SIFT_DOWN;
              end
            OP_PEEK: if (w_empty) r_out_err <= 1'b1;
              else r_out_data <= w_root;
            OP_COUNT: r_out_data <= DATA_W'(r_count);
            OP_CLEAR: r_count <= '0;
            OP_REPLACE: if (w_empty) r_out_err <= 1'b1;
              else begin
                r_out_data <= w_root;
                r_idx      <= '0;
                r_state    <= ST_SIFT_DOWN;
              end
            default: r_out_err <= 1'b1;
          endcase
        end
        ST_SIFT_UP: if (w_up_swap) begin
          r_idx <= w_par;
          if (w_par == '0) r_state <= ST_IDLE;
        end else begin
          r_state <= ST_IDLE;
        end
        ST_SIFT_DOWN: if (w_dn_swap) begin
          r_idx <= w_best_a;
          if (w_best_leaf) r_state <= ST_IDLE;
        end else begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_v    = r_out_v;
  assign out_rd   = r_out_rd;
  assign out_data = r_out_data;
  assign out_err  = r_out_err;
  assign busy     = (r_state != ST_IDLE);
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule

// File: tb/tb_c3_prio_queue.sv
// Bench for c3_prio_queue: three configurations against an unordered-array reference model.
module tb_c3_prio_queue;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0: max/unsigned DEPTH 32; 1: min/signed DEPTH 8; 2: max/unsigned DEPTH 5.
  logic        in_v     [3];
  logic [4:0]  rd       [3];
  logic [31:0] in_data  [3];
  logic        out_v    [3];
  logic [4:0]  out_rd   [3];
  logic [31:0] out_data [3];
  logic        out_err  [3];
  logic        busy     [3];
  logic        full     [3];
  logic        empty    [3];
  logic [5:0]  cnt0;
  logic [3:0]  cnt1;
  logic [2:0]  cnt2;
  int          cnt      [3];

  assign cnt[0] = 32'(cnt0);
  assign cnt[1] = 32'(cnt1);
  assign cnt[2] = 32'(cnt2);

  c3_prio_queue #(.DATA_W(32), .DEPTH(32), .MIN_MODE(0), .SIGNED_CMP(0)) u_max (
    .clk(clk), .reset(reset), .in_v(in_v[0]), .rd(rd[0]), .in_data(in_data[0]),
    .out_v(out_v[0]), .out_rd(out_rd[0]), .out_data(out_data[0]), .out_err(out_err[0]),
    .busy(busy[0]), .count(cnt0), .full(full[0]), .empty(empty[0]));

  c3_prio_queue #(.DATA_W(32), .DEPTH(8), .MIN_MODE(1), .SIGNED_CMP(1)) u_min (
    .clk(clk), .reset(reset), .in_v(in_v[1]), .rd(rd[1]), .in_data(in_data[1]),
    .out_v(out_v[1]), .out_rd(out_rd[1]), .out_data(out_data[1]), .out_err(out_err[1]),
    .busy(busy[1]), .count(cnt1), .full(full[1]), .empty(empty[1]));

  c3_prio_queue #(.DATA_W(32), .DEPTH(5), .MIN_MODE(0), .SIGNED_CMP(0)) u_d5 (
    .clk(clk), .reset(reset), .in_v(in_v[2]), .rd(rd[2]), .in_data(in_data[2]),
    .out_v(out_v[2]), .out_rd(out_rd[2]), .out_data(out_data[2]), .out_err(out_err[2]),
    .busy(busy[2]), .count(cnt2), .full(full[2]), .empty(empty[2]));

  int checks = 0;
  int errors = 0;

  // Reference model: unordered bag; the best entry is found by linear search.
  logic [31:0] mv [3][32];
  int          mc   [3];
  int          mdep [3] = '{32, 8, 5};
  int          mbnd [3] = '{5, 3, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mbeats(input int d, input logic [31:0] a, input logic [31:0] b);
    if (d == 1) return $signed(a) < $signed(b);
    return a > b;
  endfunction

  function automatic int mbest(input int d);
    int k = 0;
    for (int i = 1; i < mc[d]; i++)
      if (mbeats(d, mv[d][i], mv[d][k])) k = i;
    return k;
  endfunction

  task automatic mstep(input int d, input logic [2:0] op, input logic [31:0] x,
                       output logic [31:0] ed, output logic ee);
    int k;
    ed = '0;
    ee = 1'b0;
    case (op)
      3'd0: if (mc[d] == mdep[d]) ee = 1'b1;
            else begin mv[d][mc[d]] = x; mc[d]++; ed = 32'(mc[d]); end
      3'd1: if (mc[d] == 0) ee = 1'b1;
            else begin k = mbest(d); ed = mv[d][k]; mv[d][k] = mv[d][mc[d]-1]; mc[d]--; end
      3'd2: if (mc[d] == 0) ee = 1'b1; else ed = mv[d][mbest(d)];
      3'd3: ed = 32'(mc[d]);
      3'd4: mc[d] = 0;
      3'd5: if (mc[d] == 0) ee = 1'b1;
            else begin k = mbest(d); ed = mv[d][k]; mv[d][k] = x; end
      default: ee = 1'b1;
    endcase
  endtask

  // Wait (bounded) for busy to drop; also bounds the restructure length.
  task automatic wait_idle(input int d);
    int n = 0;
    while (busy[d] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(busy[d]), 32'd0);
    chk("busy_len_ok", 32'(n <= mbnd[d]), 32'd1);
  endtask

  // Issue one command on an idle DUT and capture its response.
  task automatic cmd(input int d, input logic [4:0] r, input logic [31:0] x,
                     output logic [31:0] od, output logic oe);
    in_v[d] = 1'b1; rd[d] = r; in_data[d] = x;
    @(posedge clk); #1;
    in_v[d] = 1'b0;
    chk("resp_v", 32'(out_v[d]), 32'd1);
    chk("resp_rd", 32'(out_rd[d]), 32'(r));
    od = out_data[d];
    oe = out_err[d];
  endtask

  task automatic run(input int d, input logic [4:0] r, input logic [31:0] x,
                     output logic [31:0] od, output logic oe);
    logic [31:0] ed;
    logic        ee;
    wait_idle(d);
    mstep(d, r[2:0], x, ed, ee);
    cmd(d, r, x, od, oe);
    chk("resp_data", od, ed);
    chk("resp_err", 32'(oe), 32'(ee));
    wait_idle(d);
    chk("count", 32'(cnt[d]), 32'(mc[d]));
    chk("empty", 32'(empty[d]), 32'(mc[d] == 0));
    chk("full", 32'(full[d]), 32'(mc[d] == mdep[d]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g, ed;
    logic        e, ee;
    logic [4:0]  r;
    int          d, sel;
    logic [31:0] x;

    for (int i = 0; i < 3; i++) begin
      in_v[i] = 1'b0; rd[i] = '0; in_data[i] = '0; mc[i] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_v", 32'(out_v[i]), 32'd0);
      chk("rst_out_rd", 32'(out_rd[i]), 32'd0);
      chk("rst_out_data", out_data[i], 32'd0);
      chk("rst_out_err", 32'(out_err[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_count", 32'(cnt[i]), 32'd0);
      chk("rst_empty", 32'(empty[i]), 32'd1);
      chk("rst_full", 32'(full[i]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Max-heap ordering.
    run(0, 5'd0, 5, g, e); chk("push5_cnt", g, 1);
    run(0, 5'd0, 9, g, e); chk("push9_cnt", g, 2);
    run(0, 5'd0, 3, g, e); chk("push3_cnt", g, 3);
    run(0, 5'd0, 7, g, e); chk("push7_cnt", g, 4);
    run(0, 5'd1, 0, g, e); chk("pop_9", g, 9);
    run(0, 5'd1, 0, g, e); chk("pop_7", g, 7);
    run(0, 5'd1, 0, g, e); chk("pop_5", g, 5);
    run(0, 5'd1, 0, g, e); chk("pop_3", g, 3); chk("pop_3_err", 32'(e), 0);
    chk("max_end_cnt", 32'(cnt[0]), 0);

    // Signed min-heap.
    run(1, 5'd0, 32'hFFFF_FFFE, g, e);
    run(1, 5'd0, 32'd4, g, e);
    run(1, 5'd0, 32'hFFFF_FFF8, g, e);
    run(1, 5'd1, 0, g, e); chk("min_pop_m8", g, 32'hFFFF_FFF8);
    run(1, 5'd1, 0, g, e); chk("min_pop_m2", g, 32'hFFFF_FFFE);
    run(1, 5'd1, 0, g, e); chk("min_pop_4", g, 32'd4);

    // DEPTH 5 full / empty boundaries.
    run(2, 5'd0, 3, g, e); run(2, 5'd0, 1, g, e); run(2, 5'd0, 4, g, e);
    run(2, 5'd0, 1, g, e); run(2, 5'd0, 5, g, e);
    run(2, 5'd0, 9, g, e);
    chk("d5_overflow_err", 32'(e), 1); chk("d5_overflow_data", g, 0);
    chk("d5_full", 32'(full[2]), 1); chk("d5_cnt", 32'(cnt[2]), 5);
    run(2, 5'd1, 0, g, e); chk("d5_pop5", g, 5);
    run(2, 5'd1, 0, g, e); chk("d5_pop4", g, 4);
    run(2, 5'd1, 0, g, e); chk("d5_pop3", g, 3);
    run(2, 5'd1, 0, g, e); chk("d5_pop1a", g, 1);
    run(2, 5'd1, 0, g, e); chk("d5_pop1b", g, 1);
    run(2, 5'd1, 0, g, e); chk("d5_empty_err", 32'(e), 1); chk("d5_empty_data", g, 0);

    // Command presented while busy is ignored.
    run(0, 5'd0, 30, g, e);
    run(0, 5'd0, 40, g, e);
    wait_idle(0);
    mstep(0, 3'd0, 60, ed, ee);
    in_v[0] = 1'b1; rd[0] = 5'd0; in_data[0] = 60;
    @(posedge clk); #1;
    chk("busy_acc_v", 32'(out_v[0]), 1);
    chk("busy_acc_data", out_data[0], ed);
    chk("busy_high", 32'(busy[0]), 1);
    in_data[0] = 100;
    @(posedge clk); #1;
    in_v[0] = 1'b0;
    chk("busy_ignored_v", 32'(out_v[0]), 0);
    wait_idle(0);
    chk("busy_ignored_cnt", 32'(cnt[0]), 3);
    run(0, 5'd2, 0, g, e); chk("busy_peek", g, 60);

    // REPLACE / PEEK / COUNT with upper rd bits echoed.
    run(0, 5'd4, 0, g, e); chk("clear_data", g, 0);
    run(0, 5'd0, 10, g, e); run(0, 5'd0, 8, g, e); run(0, 5'd0, 6, g, e);
    run(0, 5'h1D, 1, g, e); chk("replace_old", g, 10);
    run(0, 5'h0A, 0, g, e); chk("peek_8", g, 8);
    run(0, 5'h13, 0, g, e); chk("count_3", g, 3);
    run(0, 5'd6, 0, g, e);  chk("illegal6_err", 32'(e), 1);
    run(0, 5'h1F, 0, g, e); chk("illegal7_err", 32'(e), 1); chk("illegal7_data", g, 0);

    // Reset during SIFT_DOWN.
    run(0, 5'd4, 0, g, e);
    for (int i = 1; i <= 8; i++) run(0, 5'd0, 32'(i), g, e);
    wait_idle(0);
    mstep(0, 3'd1, 0, ed, ee);
    cmd(0, 5'd1, 0, g, e);
    chk("sd_pop_data", g, 8);
    chk("sd_busy", 32'(busy[0]), 1);
    reset = 1'b1;
    #1;
    chk("sd_rst_busy", 32'(busy[0]), 0);
    chk("sd_rst_cnt", 32'(cnt[0]), 0);
    chk("sd_rst_empty", 32'(empty[0]), 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) mc[i] = 0;
    @(posedge clk); #1;
    run(0, 5'd1, 0, g, e); chk("sd_post_pop_err", 32'(e), 1);

    // Randomized command mix against the model.
    for (int i = 0; i < 450; i++) begin
      d   = $urandom_range(0, 2);
      sel = $urandom_range(0, 15);
      if (sel < 6 || sel == 14)      r = 5'd0;
      else if (sel < 9)              r = 5'd1;
      else if (sel == 9)             r = 5'd2;
      else if (sel == 10)            r = 5'd3;
      else if (sel < 13)             r = 5'd5;
      else if (sel == 13)            r = 5'(6 + $urandom_range(0, 1));
      else                           r = ($urandom_range(0, 3) == 0) ? 5'd4 : 5'd1;
      r[4:3] = 2'($urandom_range(0, 3));
      if (d == 1)      x = 32'($urandom_range(0, 40)) - 32'd20;
      else if (sel[0]) x = 32'($urandom_range(0, 15));
      else             x = $urandom;
      run(d, r, x, g, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
